sample_buffer: RTL and testbench

- Parametrised sample store for the filter datapath. Successor to the single-port fixed-width load-and-read RAM wrapper.
- Has an independent write port, a random single-word read port, and a burst-read engine. The burst engine streams a contiguous window of samples, with circular wrap, into the filter MAC.
- Output reads are pipelined with a valid flag, and each burst ends with a last marker.

---
 rtl/sample_buffer_pkg.sv | 7 +
 rtl/sample_buffer_sdp_bram.sv | 18 +
 rtl/sample_buffer.sv | 100 ++++++++++
 tb/tb_sample_buffer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sample_buffer_pkg.sv
// sample_buffer_pkg: shared types and default sizes for the sample buffer.
package sample_buffer_pkg;
   typedef enum logic {IDLE, BURST} state_t;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 14;
   localparam int RD_LATENCY = 2;
endpackage

// File: rtl/sample_buffer_sdp_bram.sv
// sdp_bram: simple dual-port RAM with registered read, old data on read-during-write.
module sdp_bram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/sample_buffer.sv
// sample_buffer: sample store with single-word reads and circular burst reads, 2-cycle read latency.
module sample_buffer
   import sample_buffer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              burst_start,
   input  logic [ADDR_W-1:0] burst_base,
   input  logic [LEN_W-1:0]  burst_len,
   output logic              busy,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_last,
   output logic              burst_done
);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, ram_raddr;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] ram_rdata, rd_data_q, rd_data_d;
   logic              v1_q, v1_d, l1_q, l1_d, rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
   logic              accept, issue, issue_last;

   sdp_bram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   // cnt_q holds the reads still to issue after the one accepted with the burst
   always_comb begin
      accept     = state_q == IDLE && burst_start && burst_len != '0;
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      ram_raddr  = rd_addr;
      issue      = 1'b0;
      issue_last = 1'b0;
      if (state_q == BURST) begin
         ram_raddr  = addr_q;
         addr_d     = addr_q + ADDR_W'(1);
         cnt_d      = cnt_q - LEN_W'(1);
         issue      = 1'b1;
         issue_last = cnt_q == LEN_W'(1);
         state_d    = issue_last ? IDLE : BURST;
      end else if (accept) begin
         ram_raddr  = burst_base;
         addr_d     = burst_base + ADDR_W'(1);
         cnt_d      = burst_len - LEN_W'(1);
         issue      = 1'b1;
         issue_last = burst_len == LEN_W'(1);
         state_d    = issue_last ? IDLE : BURST;
      end else if (!burst_start && rd_req) begin
         issue = 1'b1;
      end
      v1_d       = issue;
      l1_d       = issue && issue_last;
      rd_valid_d = v1_q;
      rd_last_d  = l1_q;
      rd_data_d  = v1_q ? ram_rdata : rd_data_q;
   end

   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      if (rst) begin
         state_q    <= IDLE;
         v1_q       <= 1'b0;
         l1_q       <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         v1_q       <= v1_d;
         l1_q       <= l1_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // masking with rst silences an aborted burst already in the reset cycle
   assign busy       = state_q == BURST;
   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q & ~rst;
   assign rd_last    = rd_last_q & ~rst;
   assign burst_done = rd_last_q & ~rst;
endmodule

// File: tb/tb_sample_buffer.sv
// tb_sample_buffer: directed and random steps checked against a cycle-indexed reference model.
module tb_sample_buffer;
   import sample_buffer_pkg::*;
   localparam int DW = DEF_DATA_W;
   localparam int AW = DEF_ADDR_W;
   localparam int LW = AW + 1;
   localparam int DEPTH = 1 << AW;
   localparam int NC = 4096;

   logic          clk = 1'b0;
   logic          rst, wr_en, rd_req, burst_start;
   logic [AW-1:0] wr_addr, rd_addr, burst_base;
   logic [DW-1:0] wr_data;
   logic [LW-1:0] burst_len;
   logic          busy, rd_valid, rd_last, burst_done;
   logic [DW-1:0] rd_data;

   always #5 clk = ~clk;

   sample_buffer dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .burst_start (burst_start),
      .burst_base  (burst_base),
      .burst_len   (burst_len),
      .busy        (busy),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_last     (rd_last),
      .burst_done  (burst_done)
   );

   logic [DW-1:0] mem [DEPTH];
   bit            ev [NC];
   bit            el [NC];
   logic [DW-1:0] ed [NC];
   int            cyc, n_tests, n_fail, b_rem, nv, nd;
   logic [AW-1:0] b_addr;
   bit            eb, obs_busy;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (!rst) chk("busy", 32'(busy), 32'(eb));
      chk("rd_valid", 32'(rd_valid), 32'(ev[cyc]));
      chk("rd_last", 32'(rd_last), 32'(el[cyc]));
      chk("burst_done", 32'(burst_done), 32'(el[cyc]));
      if (ev[cyc]) chk("rd_data", 32'(rd_data), 32'(ed[cyc]));
      obs_busy = busy;
      if (rd_valid) nv++;
      if (burst_done) nd++;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // model: a burst is a list of reads, one per cycle; reads see memory before this cycle's write
   task automatic step(input bit we, input int wa, input int wd, input bit rr, input int ra,
                       input bit bs, input int bb, input int bl);
      bit iss = 0, lst = 0;
      int a = 0;
      eb = b_rem > 0;
      if (b_rem > 0) begin
         a = int'(b_addr);
         b_addr++;
         b_rem--;
         iss = 1;
         lst = b_rem == 0;
      end else if (bs) begin
         if (bl != 0) begin
            a = bb % DEPTH;
            b_addr = AW'(a + 1);
            b_rem = bl - 1;
            iss = 1;
            lst = bl == 1;
         end
      end else if (rr) begin
         a = ra % DEPTH;
         iss = 1;
      end
      if (iss) begin
         ev[cyc+RD_LATENCY] = 1;
         el[cyc+RD_LATENCY] = lst;
         ed[cyc+RD_LATENCY] = mem[a];
      end
      if (we) mem[wa % DEPTH] = DW'(wd);
      wr_en = we; wr_addr = AW'(wa); wr_data = DW'(wd);
      rd_req = rr; rd_addr = AW'(ra);
      burst_start = bs; burst_base = AW'(bb); burst_len = LW'(bl);
      tick();
      wr_en = 0; rd_req = 0; burst_start = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_rst(input int n);
      repeat (n) begin
         rst = 1;
         for (int i = cyc; i < cyc + 40 && i < NC; i++) begin
            ev[i] = 0;
            el[i] = 0;
         end
         b_rem = 0;
         tick();
      end
      rst = 0;
   endtask

   initial begin
      int g, v0, d0;
      rst = 1; wr_en = 0; rd_req = 0; burst_start = 0;
      wr_addr = '0; wr_data = '0; rd_addr = '0; burst_base = '0; burst_len = '0;
      cyc = 0; n_tests = 0; n_fail = 0; b_rem = 0; nv = 0; nd = 0; eb = 0; b_addr = '0;
      @(posedge clk);
      #1;
      do_rst(2);
      chk("reset_rd_data", 32'(rd_data), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      // single write then read
      step(1, 5, 'h1234, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 5, 0, 0, 0);
      idle(3);
      // read-during-write collision
      step(1, 7, 'hAAAA, 0, 0, 0, 0, 0);
      step(1, 7, 'h5555, 1, 7, 0, 0, 0);
      step(0, 0, 0, 1, 7, 0, 0, 0);
      idle(3);
      // circular wrap burst
      for (int k = DEPTH - 8; k < DEPTH; k++) step(1, k, k, 0, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) step(1, k, k, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, DEPTH - 4, 6);
      idle(8);
      // burst beats rd_req; rd_req in BURST and zero-length burst are ignored
      v0 = nv;
      step(0, 0, 0, 1, 5, 1, 0, 3);
      step(0, 0, 0, 1, 5, 0, 0, 0);
      step(0, 0, 0, 1, 6, 0, 0, 0);
      idle(3);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      idle(3);
      chk("prio_words", 32'(nv - v0), 32'd3);
      // reset in the 4th busy cycle of a 10-word burst
      d0 = nd;
      step(0, 0, 0, 0, 0, 1, 0, 10);
      idle(3);
      do_rst(1);
      idle(12);
      chk("abort_done", 32'(nd - d0), 32'd0);
      // back-to-back bursts, second issued once busy is seen low
      v0 = nv; d0 = nd; g = 0;
      step(0, 0, 0, 0, 0, 1, 2, 2);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      while (obs_busy && g < 10) begin
         step(0, 0, 0, 0, 0, 0, 0, 0);
         g++;
      end
      chk("b2b_busy_drop", 32'(g < 10), 32'd1);
      step(0, 0, 0, 0, 0, 1, 4, 2);
      idle(4);
      chk("b2b_words", 32'(nv - v0), 32'd4);
      chk("b2b_done", 32'(nd - d0), 32'd2);
      // random traffic over a preloaded window
      for (int k = 0; k < 64; k++) step(1, k, $urandom, 0, 0, 0, 0, 0);
      for (int k = 0; k < 300; k++)
         step($urandom_range(0, 1), $urandom_range(0, 63), $urandom, $urandom_range(0, 1),
              $urandom_range(0, 63), $urandom_range(0, 5) == 0, $urandom_range(0, 55),
              $urandom_range(0, 8));
      idle(12);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
